// File: rtl/mskand_hpc3_arb_if.sv
// Bundle of requester, randomness, gadget and response signals around one shared HPC3 AND gadget.
// slave = arbiter view, master = environment view (requesters, randomness source, gadget, sink).
interface mskand_hpc3_arb_if #(
   parameter int d    = 2,
   parameter int NREQ = 4
);
   localparam int RNDW = d * (d - 1);
   localparam int IDW  = (NREQ > 1) ? $clog2(NREQ) : 1;

   logic [NREQ-1:0]   req_valid;
   logic [NREQ-1:0]   req_ready;
   logic [NREQ*d-1:0] req_ina;
   logic [NREQ*d-1:0] req_inb;
   logic [RNDW-1:0]   rnd_in;
   logic              rnd_valid;
   logic              rnd_ready;
   logic [d-1:0]      g_ina;
   logic [d-1:0]      g_inb;
   logic [RNDW-1:0]   g_rnd;
   logic [d-1:0]      g_out;
   logic              resp_valid;
   logic              resp_ready;
   logic [d-1:0]      resp_data;
   logic [IDW-1:0]    resp_id;

   modport slave (
      input  req_valid, req_ina, req_inb, rnd_in, rnd_valid, g_out, resp_ready,
      output req_ready, rnd_ready, g_ina, g_inb, g_rnd, resp_valid, resp_data, resp_id
   );

   modport master (
      output req_valid, req_ina, req_inb, rnd_in, rnd_valid, g_out, resp_ready,
      input  req_ready, rnd_ready, g_ina, g_inb, g_rnd, resp_valid, resp_data, resp_id
   );
endinterface

// File: rtl/mskand_hpc3_arb.sv
// Round-robin sharing of one 1-cycle HPC3 AND gadget among NREQ masked requesters; issue->resp_valid 2 cycles.
// At most 2 results outstanding (inflight + FIFO); MSKAND_ARB_IDLE_ZERO_EN zeroes gadget inputs when idle.
module mskand_hpc3_arb #(
   parameter int d    = 2,
   parameter int NREQ = 4
) (
   input logic             clk,
   input logic             rst,
   mskand_hpc3_arb_if.slave bus
);
   localparam int RNDW = d * (d - 1);
   localparam int IDW  = (NREQ > 1) ? $clog2(NREQ) : 1;

   logic [IDW-1:0] ptr_q, ptr_d;
   logic           inflight_q;
   logic [IDW-1:0] infl_id_q;
   logic [d-1:0]   data_q [2];
   logic [IDW-1:0] id_q   [2];
   logic           wr_q, rd_q;
   logic [1:0]     cnt_q, cnt_d;

   logic [IDW-1:0] cand;
   logic           any_vld;
   int             idx;
   logic [d-1:0]   sel_a, sel_b;
   logic [2:0]     occ;
   logic           push, pop, credit_ok, issue;

   // Walk downward so the last hit is the first valid index after the pointer.
   always_comb begin
      cand    = IDW'((int'(ptr_q) + 1) % NREQ);
      any_vld = 1'b0;
      idx     = 0;
      for (int i = NREQ; i >= 1; i--) begin
         idx = (int'(ptr_q) + i) % NREQ;
         if (bus.req_valid[idx]) begin
            cand    = IDW'(idx);
            any_vld = 1'b1;
         end
      end
   end

   assign push      = inflight_q;
   assign pop       = bus.resp_valid & bus.resp_ready;
   assign occ       = 3'(cnt_q) + 3'(inflight_q) - 3'(pop);
   assign credit_ok = (occ < 3'd2);
   assign issue     = ~rst & any_vld & bus.rnd_valid & credit_ok;

   always_comb begin
      sel_a = bus.req_ina[int'(cand)*d +: d];
      sel_b = bus.req_inb[int'(cand)*d +: d];
      bus.req_ready = '0;
      if (issue) bus.req_ready[cand] = 1'b1;
   end

   assign bus.rnd_ready = issue;

`ifdef MSKAND_ARB_IDLE_ZERO_EN
   assign bus.g_ina = issue ? sel_a : '0;
   assign bus.g_inb = issue ? sel_b : '0;
   assign bus.g_rnd = issue ? bus.rnd_in : '0;
`else
   assign bus.g_ina = sel_a;
   assign bus.g_inb = sel_b;
   assign bus.g_rnd = bus.rnd_in;
`endif

   assign ptr_d = issue ? cand : ptr_q;
   assign cnt_d = cnt_q + 2'(push) - 2'(pop);

   // Credit check guarantees a push never lands on a full FIFO without a same-cycle pop.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ptr_q      <= IDW'(NREQ - 1);
         inflight_q <= 1'b0;
         infl_id_q  <= '0;
         wr_q       <= 1'b0;
         rd_q       <= 1'b0;
         cnt_q      <= 2'd0;
         for (int i = 0; i < 2; i++) begin
            data_q[i] <= '0;
            id_q[i]   <= '0;
         end
      end else begin
         ptr_q      <= ptr_d;
         inflight_q <= issue;
         if (issue) infl_id_q <= cand;
         if (push) begin
            data_q[wr_q] <= bus.g_out;
            id_q[wr_q]   <= infl_id_q;
            wr_q         <= ~wr_q;
         end
         if (pop) rd_q <= ~rd_q;
         cnt_q <= cnt_d;
      end
   end

   assign bus.resp_valid = (cnt_q != 2'd0);
   assign bus.resp_data  = data_q[rd_q];
   assign bus.resp_id    = id_q[rd_q];
endmodule

// File: tb/tb_mskand_hpc3_arb.sv
// Directed and random stimulus for mskand_hpc3_arb against a queue-based model of issue/credit/response order.
module tb_mskand_hpc3_arb;
   localparam int D  = 2;
   localparam int NR = 4;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_cmp  = 0;
   int   n_fail = 0;

   typedef struct {
      int id;
      int val;
      int cyc;
   } exp_t;

   exp_t q[$];
   int   ptr_m = NR - 1;
   int   cyc   = 0;

   mskand_hpc3_arb_if #(.d(D), .NREQ(NR)) bus ();

   mskand_hpc3_arb #(.d(D), .NREQ(NR)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   // Environment gadget: one-cycle masked AND, output sharing XORs to AND of the input sharings.
   always @(posedge clk)
      bus.g_out <= {bus.g_rnd[0], ((^bus.g_ina) & (^bus.g_inb)) ^ bus.g_rnd[0]};

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Called at a falling edge with inputs already driven; returns at the next falling edge.
   task automatic step();
      int   grant;
      int   idx;
      bit   iss, pop_m, rv;
      int   val;
      logic [1:0] a, b;
      #1;
      grant = -1;
      for (int i = 1; i <= NR; i++) begin
         idx = (ptr_m + i) % NR;
         if (bus.req_valid[idx] && grant < 0) grant = idx;
      end
      if (rst) begin
         q.delete();
         ptr_m = NR - 1;
      end
      rv    = !rst && q.size() > 0 && q[0].cyc <= cyc - 2;
      pop_m = rv && bus.resp_ready;
      iss   = !rst && grant >= 0 && bus.rnd_valid && (q.size() - int'(pop_m) < 2);

      check("req_ready", 32'(bus.req_ready), iss ? (32'd1 << grant) : 32'd0);
      check("rnd_ready", 32'(bus.rnd_ready), 32'(iss));
      check("resp_valid", 32'(bus.resp_valid), 32'(rv));
      if (rv) begin
         check("resp_id", 32'(bus.resp_id), 32'(q[0].id));
         check("resp_xor", 32'(^bus.resp_data), 32'(q[0].val));
      end
      if (grant >= 0) begin
         a = bus.req_ina[grant*D +: D];
         b = bus.req_inb[grant*D +: D];
      end else begin
         a = '0;
         b = '0;
      end
      if (iss) begin
         check("g_ina", 32'(bus.g_ina), 32'(a));
         check("g_inb", 32'(bus.g_inb), 32'(b));
         check("g_rnd", 32'(bus.g_rnd), 32'(bus.rnd_in));
      end else begin
`ifdef MSKAND_ARB_IDLE_ZERO_EN
         check("g_ina_idle", 32'(bus.g_ina), 32'd0);
         check("g_inb_idle", 32'(bus.g_inb), 32'd0);
         check("g_rnd_idle", 32'(bus.g_rnd), 32'd0);
`else
         if (grant >= 0 && !rst) begin
            check("g_ina_cand", 32'(bus.g_ina), 32'(a));
            check("g_inb_cand", 32'(bus.g_inb), 32'(b));
         end
`endif
      end

      if (pop_m) void'(q.pop_front());
      if (iss) begin
         val = int'((^a) & (^b));
         q.push_back('{id: grant, val: val, cyc: cyc});
         ptr_m = grant;
      end
      cyc++;
      @(negedge clk);
   endtask

   task automatic drive(input logic [3:0] rv, input logic [7:0] ia, input logic [7:0] ib,
                        input logic [1:0] rn, input logic rnv, input logic rr);
      bus.req_valid  = rv;
      bus.req_ina    = ia;
      bus.req_inb    = ib;
      bus.rnd_in     = rn;
      bus.rnd_valid  = rnv;
      bus.resp_ready = rr;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      step();
      step();
      rst = 1'b0;
   endtask

   initial begin
      drive(4'b1111, 8'hA5, 8'h3C, 2'b01, 1'b1, 1'b1);
      @(negedge clk);
      // Reset with requests and randomness present: nothing may be granted.
      step();
      step();
      rst = 1'b0;

      // Single requester 1, spec operands, then operands whose AND is 1.
      do_reset();
      drive(4'b0010, 8'b0000_0100, 8'b0000_1100, 2'b01, 1'b1, 1'b1);
      step();
      drive(4'b0000, 8'h00, 8'h00, 2'b00, 1'b0, 1'b1);
      for (int i = 0; i < 3; i++) step();
      drive(4'b0010, 8'b0000_0100, 8'b0000_1000, 2'b10, 1'b1, 1'b1);
      step();
      drive(4'b0000, 8'h00, 8'h00, 2'b00, 1'b0, 1'b1);
      for (int i = 0; i < 3; i++) step();

      // All requesters, full throughput: grants 0,1,2,3,0,...
      do_reset();
      for (int i = 0; i < 8; i++) begin
         drive(4'b1111, 8'($urandom), 8'($urandom), 2'($urandom), 1'b1, 1'b1);
         step();
      end
      drive(4'b0000, 8'h00, 8'h00, 2'b00, 1'b0, 1'b1);
      for (int i = 0; i < 3; i++) step();

      // Sink stalled: only two issues accepted, then drain.
      do_reset();
      for (int i = 0; i < 6; i++) begin
         drive(4'b1111, 8'($urandom), 8'($urandom), 2'($urandom), 1'b1, 1'b0);
         step();
      end
      for (int i = 0; i < 6; i++) begin
         drive(4'b1111, 8'($urandom), 8'($urandom), 2'($urandom), 1'b1, 1'b1);
         step();
      end

      // No randomness: no grant, pointer held; then grant 0.
      do_reset();
      drive(4'b1111, 8'h5A, 8'hC3, 2'b11, 1'b0, 1'b1);
      step();
      step();
      drive(4'b1111, 8'h5A, 8'hC3, 2'b11, 1'b1, 1'b1);
      step();
      drive(4'b0000, 8'h00, 8'h00, 2'b00, 1'b0, 1'b1);
      for (int i = 0; i < 3; i++) step();

      // Reset in the cycle after an issue: its result must vanish, pointer restarts.
      do_reset();
      drive(4'b0100, 8'hFF, 8'h30, 2'b01, 1'b1, 1'b1);
      step();
      drive(4'b0000, 8'h00, 8'h00, 2'b00, 1'b0, 1'b1);
      rst = 1'b1;
      step();
      rst = 1'b0;
      for (int i = 0; i < 3; i++) step();
      drive(4'b1111, 8'h12, 8'h34, 2'b10, 1'b1, 1'b1);
      step();
      drive(4'b0000, 8'h00, 8'h00, 2'b00, 1'b0, 1'b1);
      for (int i = 0; i < 3; i++) step();

      // Random traffic with random randomness availability and backpressure.
      for (int i = 0; i < 400; i++) begin
         drive(4'($urandom), 8'($urandom), 8'($urandom), 2'($urandom),
               1'(($urandom % 4) != 0), 1'(($urandom % 3) != 0));
         step();
      end
      drive(4'b0000, 8'h00, 8'h00, 2'b00, 1'b0, 1'b1);
      for (int i = 0; i < 4; i++) step();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end
endmodule
